// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard sequencer.
package hazard_pkg;

   // RUN: normal flow. LD_STALL: extra load-use bubbles still owed.
   // MEM_WAIT: pipeline frozen behind a busy data memory.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam int DEF_REG_W             = 3;
   localparam int DEF_LOAD_STALL_CYCLES = 1;
   localparam int DEF_MEM_TIMEOUT       = 64;
   localparam int DEF_CNT_W             = 16;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next value: hold at all-ones once reached so the count never wraps.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + ONE;
      end
   end

   // Counter register; clear has priority over any increment.
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and the
// memory-busy freeze for the 5-stage datapath.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W             = DEF_REG_W,
   parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
   parameter int MEM_TIMEOUT       = DEF_MEM_TIMEOUT,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_EX_memRead,
   input  logic [REG_W-1:0] ID_EX_Rt,
   input  logic [REG_W-1:0] IF_ID_Rs,
   input  logic [REG_W-1:0] IF_ID_Rt,
   input  logic             IF_ID_useRt,
   input  logic             EX_branchTaken,
   input  logic             mem_busy,
   output logic             pcWrite,
   output logic             IF_ID_write,
   output logic             ID_EX_write,
   output logic             EX_MEM_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             MEM_WB_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic             mem_error
);

   localparam int               TMO_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
   localparam logic [2:0]       LD_INIT = 3'(LOAD_STALL_CYCLES - 1);

   state_e           state_q, state_d;
   logic [2:0]       ld_cnt_q, ld_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             mem_error_q, mem_error_d;
   state_e           eff_state;
   logic             hazard;

   // Outputs and next state from registered state plus current inputs.
   // Leaving MEM_WAIT is resolved here so the release cycle acts like
   // the state the freeze interrupted, without an extra idle cycle.
   always_comb begin
      pcWrite      = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      MEM_WB_flush = 1'b0;
      state_d      = state_q;
      ld_cnt_d     = ld_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      mem_error_d  = mem_error_q;

      hazard = ID_EX_memRead &
               ((ID_EX_Rt == IF_ID_Rs) | (IF_ID_useRt & (ID_EX_Rt == IF_ID_Rt)));

      eff_state = state_q;
      if (state_q == MEM_WAIT) begin
         eff_state = (ld_cnt_q != 3'd0) ? LD_STALL : RUN;
      end

      if (rst) begin
         pcWrite      = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
         MEM_WB_flush = 1'b1;
      end else if (mem_busy) begin
         pcWrite      = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
         MEM_WB_flush = 1'b1;
         state_d      = MEM_WAIT;
         if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
         end
         if (tmo_cnt_d == TMO_MAX) begin
            mem_error_d = 1'b1;
         end
      end else begin
         tmo_cnt_d = '0;
         if (EX_branchTaken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = RUN;
            ld_cnt_d    = 3'd0;
         end else if (eff_state == LD_STALL) begin
            pcWrite     = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (ld_cnt_q <= 3'd1) begin
               state_d  = RUN;
               ld_cnt_d = 3'd0;
            end else begin
               state_d  = LD_STALL;
               ld_cnt_d = ld_cnt_q - 3'd1;
            end
         end else if (hazard) begin
            pcWrite     = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
               state_d  = LD_STALL;
               ld_cnt_d = LD_INIT;
            end else begin
               state_d  = RUN;
               ld_cnt_d = 3'd0;
            end
         end else begin
            state_d = RUN;
         end
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         ld_cnt_q    <= 3'd0;
         tmo_cnt_q   <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (~pcWrite & ~rst),
      .count (stall_count)
   );

   assign mem_error = mem_error_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (LOAD_STALL_CYCLES=2, CNT_W=4).
module tb_hazard_ctrl;

   // Output bundle order: pcWrite, IF_ID_w, ID_EX_w, EX_MEM_w, IF_ID_f, ID_EX_f, MEM_WB_f
   localparam logic [6:0] RUN_O   = 7'b1111_000;
   localparam logic [6:0] RST_O   = 7'b0000_111;
   localparam logic [6:0] STALL_O = 7'b0011_010;
   localparam logic [6:0] BR_O    = 7'b1111_110;
   localparam logic [6:0] MEM_O   = 7'b0000_001;

   logic       clk;
   logic       rst;
   logic       ID_EX_memRead;
   logic [2:0] ID_EX_Rt;
   logic [2:0] IF_ID_Rs;
   logic [2:0] IF_ID_Rt;
   logic       IF_ID_useRt;
   logic       EX_branchTaken;
   logic       mem_busy;
   logic       pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write;
   logic       IF_ID_flush, ID_EX_flush, MEM_WB_flush;
   logic [3:0] stall_count;
   logic       mem_error;
   logic [6:0] obs;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(
      .REG_W             (3),
      .LOAD_STALL_CYCLES (2),
      .MEM_TIMEOUT       (64),
      .CNT_W             (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_EX_memRead  (ID_EX_memRead),
      .ID_EX_Rt       (ID_EX_Rt),
      .IF_ID_Rs       (IF_ID_Rs),
      .IF_ID_Rt       (IF_ID_Rt),
      .IF_ID_useRt    (IF_ID_useRt),
      .EX_branchTaken (EX_branchTaken),
      .mem_busy       (mem_busy),
      .pcWrite        (pcWrite),
      .IF_ID_write    (IF_ID_write),
      .ID_EX_write    (ID_EX_write),
      .EX_MEM_write   (EX_MEM_write),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_flush    (ID_EX_flush),
      .MEM_WB_flush   (MEM_WB_flush),
      .stall_count    (stall_count),
      .mem_error      (mem_error)
   );

   assign obs = {pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write,
                 IF_ID_flush, ID_EX_flush, MEM_WB_flush};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic idle_inputs();
      ID_EX_memRead  = 1'b0;
      ID_EX_Rt       = 3'd0;
      IF_ID_Rs       = 3'd0;
      IF_ID_Rt       = 3'd0;
      IF_ID_useRt    = 1'b0;
      EX_branchTaken = 1'b0;
      mem_busy       = 1'b0;
   endtask

   // Entered and left on a falling edge; one reset cycle then release.
   task automatic reset_dut();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_hazard(input logic [2:0] rt, input logic [2:0] rs,
                             input logic [2:0] idrt, input logic use_rt);
      ID_EX_memRead = 1'b1;
      ID_EX_Rt      = rt;
      IF_ID_Rs      = rs;
      IF_ID_Rt      = idrt;
      IF_ID_useRt   = use_rt;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         rst = 1'b1;
         #2;
         checks++;
         if (obs !== RST_O || stall_count !== 4'd0 || mem_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold cyc=%0d obs=%b cnt=%0d err=%b expected obs=%b cnt=0 err=0",
                     i, obs, stall_count, mem_error, RST_O);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      #2;
      checks++;
      if (obs !== RUN_O || stall_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_release obs=%b cnt=%0d expected obs=%b cnt=0", obs, stall_count, RUN_O);
      end
      @(negedge clk);
   endtask

   task automatic test_load_use();
      logic [6:0] exp_o [6] = '{STALL_O, STALL_O, RUN_O, RUN_O, STALL_O, STALL_O};
      reset_dut();
      for (int c = 0; c < 7; c++) begin
         idle_inputs();
         case (c)
            0: set_hazard(3'd3, 3'd3, 3'd0, 1'b0);
            3: set_hazard(3'd3, 3'd4, 3'd3, 1'b0);
            4: set_hazard(3'd3, 3'd4, 3'd3, 1'b1);
            default: ;
         endcase
         #2;
         if (c < 6) begin
            checks++;
            if (obs !== exp_o[c]) begin
               failures++;
               $display("[TB] FAIL load_use cyc=%0d obs=%b expected=%b", c, obs, exp_o[c]);
            end
         end
         if (c == 2) begin
            checks++;
            if (stall_count !== 4'd2) begin
               failures++;
               $display("[TB] FAIL load_use_count got=%0d expected=2", stall_count);
            end
         end
         if (c == 6) begin
            checks++;
            if (obs !== RUN_O || stall_count !== 4'd4) begin
               failures++;
               $display("[TB] FAIL load_use_rt_done obs=%b cnt=%0d expected obs=%b cnt=4",
                        obs, stall_count, RUN_O);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      reset_dut();
      set_hazard(3'd5, 3'd5, 3'd0, 1'b0);
      EX_branchTaken = 1'b1;
      #2;
      checks++;
      if (obs !== BR_O) begin
         failures++;
         $display("[TB] FAIL branch_over_hazard obs=%b expected=%b", obs, BR_O);
      end
      @(negedge clk);
      idle_inputs();
      #2;
      checks++;
      if (obs !== RUN_O || stall_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL branch_no_stall obs=%b cnt=%0d expected obs=%b cnt=0", obs, stall_count, RUN_O);
      end
      @(negedge clk);
      // Branch arriving while a load-use bubble is still owed cancels it.
      set_hazard(3'd2, 3'd2, 3'd0, 1'b0);
      @(negedge clk);
      idle_inputs();
      EX_branchTaken = 1'b1;
      #2;
      checks++;
      if (obs !== BR_O) begin
         failures++;
         $display("[TB] FAIL branch_in_ldstall obs=%b expected=%b", obs, BR_O);
      end
      @(negedge clk);
      idle_inputs();
      #2;
      checks++;
      if (obs !== RUN_O || stall_count !== 4'd1) begin
         failures++;
         $display("[TB] FAIL branch_after_ldstall obs=%b cnt=%0d expected obs=%b cnt=1",
                  obs, stall_count, RUN_O);
      end
      @(negedge clk);
   endtask

   task automatic test_mem_busy_ldstall();
      logic [6:0] exp_o [7] = '{STALL_O, MEM_O, MEM_O, MEM_O, MEM_O, STALL_O, RUN_O};
      reset_dut();
      for (int c = 0; c < 7; c++) begin
         idle_inputs();
         if (c == 0) set_hazard(3'd1, 3'd1, 3'd0, 1'b0);
         if (c >= 1 && c <= 4) mem_busy = 1'b1;
         if (c == 2) EX_branchTaken = 1'b1;
         if (c == 3) set_hazard(3'd6, 3'd6, 3'd0, 1'b0);
         #2;
         checks++;
         if (obs !== exp_o[c]) begin
            failures++;
            $display("[TB] FAIL mem_busy_ldstall cyc=%0d obs=%b expected=%b", c, obs, exp_o[c]);
         end
         @(negedge clk);
      end
      #2;
      checks++;
      if (stall_count !== 4'd6) begin
         failures++;
         $display("[TB] FAIL mem_busy_count got=%0d expected=6", stall_count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_sequence();
      reset_dut();
      set_hazard(3'd4, 3'd4, 3'd0, 1'b0);
      @(negedge clk);
      reset_dut();
      #2;
      checks++;
      if (obs !== RUN_O || stall_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_ldstall obs=%b cnt=%0d expected obs=%b cnt=0", obs, stall_count, RUN_O);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt;
      reset_dut();
      for (int k = 1; k <= 20; k++) begin
         mem_busy = 1'b1;
         exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
         #2;
         checks++;
         if (stall_count !== exp_cnt || obs !== MEM_O) begin
            failures++;
            $display("[TB] FAIL saturation cyc=%0d cnt=%0d obs=%b expected cnt=%0d obs=%b",
                     k, stall_count, obs, exp_cnt, MEM_O);
         end
         @(negedge clk);
      end
      mem_busy = 1'b0;
      #2;
      checks++;
      if (stall_count !== 4'd15 || obs !== RUN_O) begin
         failures++;
         $display("[TB] FAIL saturation_hold cnt=%0d obs=%b expected cnt=15 obs=%b", stall_count, obs, RUN_O);
      end
      @(negedge clk);
   endtask

   task automatic test_mem_timeout();
      reset_dut();
      for (int k = 1; k <= 64; k++) begin
         mem_busy = 1'b1;
         #2;
         if (k == 1 || k == 63 || k == 64) begin
            checks++;
            if (mem_error !== 1'b0) begin
               failures++;
               $display("[TB] FAIL timeout_early cyc=%0d err=%b expected=0", k, mem_error);
            end
         end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         mem_busy = 1'b0;
         #2;
         checks++;
         if (mem_error !== 1'b1 || obs !== RUN_O) begin
            failures++;
            $display("[TB] FAIL timeout_sticky cyc=%0d err=%b obs=%b expected err=1 obs=%b",
                     k, mem_error, obs, RUN_O);
         end
         @(negedge clk);
      end
      reset_dut();
      #2;
      checks++;
      if (mem_error !== 1'b0 || stall_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL timeout_reset err=%b cnt=%0d expected err=0 cnt=0", mem_error, stall_count);
      end
      @(negedge clk);
   endtask

   // Scenario sequence.
   initial begin
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_mem_busy_ldstall();
      test_reset_mid_sequence();
      test_saturation();
      test_mem_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
